// File: rtl/weight_fetch_seq.sv
`default_nettype none
// ------------------------------------------------------------------------
// weight_fetch_seq : staggered multi-lane weight-RAM burst read sequencer
// Rev 1.0
// ------------------------------------------------------------------------
module weight_fetch_seq #(
  parameter int LANES   = 6,
  parameter int AW      = 13,
  parameter int DW      = 8,
  parameter int LW      = 13,
  parameter int RAM_LAT = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [AW-1:0]       i_base,
  input  logic [LW-1:0]       i_len,
  input  logic                i_stall,
  input  logic                i_abort,
  output logic [LANES-1:0]    o_rd_en,
  output logic [LANES*AW-1:0] o_addr,
  input  logic [LANES*DW-1:0] i_rdata,
  output logic [LANES*DW-1:0] o_data,
  output logic [LANES-1:0]    o_vld,
  output logic                o_data_en,
  output logic                o_busy,
  output logic                o_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_addr0;
  logic [LW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_data_en;

  logic            w_issue;
  logic            w_en   [LANES];
  logic [AW-1:0]   w_addr [LANES];
  logic [LANES-1:0] w_pend;

  // Lane 0 issues in the same cycle the stall is sampled low.
  assign w_issue = (r_state == S_RUN) && !i_stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_addr0 <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_abort) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // r_done marks the completion cycle, in which a new start is refused.
          if (i_start && !r_done) begin
            r_addr0 <= i_base;
            r_cnt   <= i_len;
            r_busy  <= 1'b1;
            if (i_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end else if (r_done) begin
            r_busy <= 1'b0;
          end
        end
        S_RUN: begin
          if (!i_stall) begin
            r_addr0 <= r_addr0 + AW'(1);
            r_cnt   <= r_cnt - LW'(1);
            if (r_cnt == LW'(1)) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pend == '0) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data_en <= 1'b0;
    end else begin
      r_data_en <= |o_vld;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [RAM_LAT-1:0] r_vd;
    logic [RAM_LAT-1:0] w_vnext;

    if (k == 0) begin : g_head
      assign w_en[k]   = w_issue;
      assign w_addr[k] = r_addr0;
    end else begin : g_tail
      logic          r_en;
      logic [AW-1:0] r_addr;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_en   <= 1'b0;
          r_addr <= '0;
        end else begin
          r_en   <= i_abort ? 1'b0 : w_en[k-1];
          r_addr <= w_addr[k-1];
        end
      end
      assign w_en[k]   = r_en;
      assign w_addr[k] = r_addr;
    end

    if (RAM_LAT == 1) begin : g_lat1
      assign w_vnext = w_en[k];
    end else begin : g_latn
      assign w_vnext = {r_vd[RAM_LAT-2:0], w_en[k]};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_vd <= '0;
      end else if (i_abort) begin
        r_vd <= '0;
      end else begin
        r_vd <= w_vnext;
      end
    end

    // Anything still in flight after the coming edge keeps DRAIN waiting.
    assign w_pend[k]            = |w_vnext;
    assign o_rd_en[k]           = w_en[k];
    assign o_addr[k*AW +: AW]   = w_addr[k];
    assign o_vld[k]             = r_vd[RAM_LAT-1];
  end

  assign o_data    = i_rdata;
  assign o_data_en = r_data_en;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule
`default_nettype wire
